// File: rtl/gpc15_3_seq_reducer_pkg.sv
// Shared constants, FSM state type and width helpers for the sequential GPC(1,5;3) reducer.
package gpc15_3_seq_reducer_pkg;

    localparam int unsigned GPC15_3_IN0  = 5;
    localparam int unsigned GPC15_3_IN1  = 1;
    localparam int unsigned GPC15_3_OUTW = 3;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    // Run cycles: enough 5-bit weight-1 slices and 1-bit weight-2 slices to cover both operands.
    function automatic int unsigned calc_ncyc(int unsigned n1, int unsigned n2);
        int unsigned c1;
        c1 = (n1 + GPC15_3_IN0 - 1) / GPC15_3_IN0;
        return (c1 > n2) ? c1 : n2;
    endfunction

    function automatic int unsigned calc_rw(int unsigned n1, int unsigned n2);
        return int'($clog2(n1 + 2 * n2 + 1));
    endfunction

endpackage

// File: rtl/gpc15_3_seq_reducer_if.sv
// Operand/result handshake bundle for the sequential reducer.
interface gpc15_3_seq_reducer_if
    import gpc15_3_seq_reducer_pkg::*;
#(
    parameter int unsigned N1 = 20,
    parameter int unsigned N2 = 4
);
    localparam int unsigned RW = calc_rw(N1, N2);

    logic          in_valid;
    logic          in_ready;
    logic [N1-1:0] in_ones;
    logic [N2-1:0] in_twos;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_sum;
    logic          busy;

    modport master (
        output in_valid, in_ones, in_twos, out_ready,
        input  in_ready, out_valid, out_sum, busy
    );

    modport slave (
        input  in_valid, in_ones, in_twos, out_ready,
        output in_ready, out_valid, out_sum, busy
    );

endinterface

// File: rtl/gpc15_3_seq_reducer_gpc15_3.sv
// Combinational GPC(1,5;3): five weight-1 bits plus one weight-2 bit into a 3-bit count.
module gpc15_3_seq_reducer_gpc15_3
    import gpc15_3_seq_reducer_pkg::*;
(
    input  logic [GPC15_3_IN0-1:0]  src0,
    input  logic [GPC15_3_IN1-1:0]  src1,
    output logic [GPC15_3_OUTW-1:0] dst
);

    always_comb begin
        dst = '0;
        for (int i = 0; i < int'(GPC15_3_IN0); i++) begin
            dst = dst + GPC15_3_OUTW'(src0[i]);
        end
        for (int i = 0; i < int'(GPC15_3_IN1); i++) begin
            dst = dst + (GPC15_3_OUTW'(src1[i]) << 1);
        end
    end

endmodule

// File: rtl/gpc15_3_seq_reducer.sv
// Weighted popcount engine: one shared GPC(1,5;3) fed a slice per cycle, results accumulated.
module gpc15_3_seq_reducer
    import gpc15_3_seq_reducer_pkg::*;
#(
    parameter int unsigned N1 = 20,
    parameter int unsigned N2 = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    gpc15_3_seq_reducer_if.slave  bus
);

    localparam int unsigned NCYC = calc_ncyc(N1, N2);
    localparam int unsigned RW   = calc_rw(N1, N2);
    localparam int unsigned S1W  = GPC15_3_IN0 * NCYC;
    localparam int unsigned S2W  = GPC15_3_IN1 * NCYC;
    localparam int unsigned CW   = $clog2(NCYC + 1);

    state_e                  state_q, state_d;
    logic [S1W-1:0]          sr1_q, sr1_d;
    logic [S2W-1:0]          sr2_q, sr2_d;
    logic [RW-1:0]           acc_q, acc_d;
    logic [RW-1:0]           sum_q, sum_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [GPC15_3_OUTW-1:0] dst;

    gpc15_3_seq_reducer_gpc15_3 u_gpc15_3 (
        .src0 (sr1_q[GPC15_3_IN0-1:0]),
        .src1 (sr2_q[GPC15_3_IN1-1:0]),
        .dst  (dst)
    );

    always_comb begin
        state_d = state_q;
        sr1_d   = sr1_q;
        sr2_d   = sr2_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    // Shift registers are sized to whole slices; unused tail bits stay zero.
                    sr1_d          = '0;
                    sr1_d[N1-1:0]  = bus.in_ones;
                    sr2_d          = '0;
                    sr2_d[N2-1:0]  = bus.in_twos;
                    acc_d          = '0;
                    cnt_d          = CW'(NCYC);
                    state_d        = StRun;
                end
            end
            StRun: begin
                acc_d = acc_q + RW'(dst);
                sr1_d = sr1_q >> GPC15_3_IN0;
                sr2_d = sr2_q >> GPC15_3_IN1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    sum_d   = acc_d;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    sum_d   = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sr1_q   <= '0;
            sr2_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr1_q   <= sr1_d;
            sr2_q   <= sr2_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.busy      = (state_q != StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.out_sum   = sum_q;

endmodule

// File: tb/tb_gpc15_3_seq_reducer.sv
// Bench for the sequential reducer: vector table and corner sequences on N1=20/N2=4, random run on N1=7/N2=1.
module tb_gpc15_3_seq_reducer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gpc15_3_seq_reducer_if #(.N1(20), .N2(4)) bus_a ();
    gpc15_3_seq_reducer_if #(.N1(7),  .N2(1)) bus_b ();

    gpc15_3_seq_reducer #(.N1(20), .N2(4)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    gpc15_3_seq_reducer #(.N1(7), .N2(1)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    typedef struct {
        logic [19:0] ones;
        logic [3:0]  twos;
        int          exp;
        string       name;
    } vec_t;

    vec_t vecs[7];
    int   checks = 0;
    int   errors = 0;
    int   sb_a[$];
    int   sb_b[$];
    bit   b_done = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Full transaction on DUT A, optionally holding out_ready low for 'hold' cycles in DONE.
    task automatic send_a(input logic [19:0] ones, input logic [3:0] twos, input int exp,
                          input string name, input int hold);
        int cyc;
        int want;
        cyc = 0;
        @(negedge clk);
        while (!bus_a.in_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({name, " in_ready"}, int'(bus_a.in_ready), 1);
        bus_a.in_ones  = ones;
        bus_a.in_twos  = twos;
        bus_a.in_valid = 1'b1;
        @(posedge clk);
        sb_a.push_back(exp);
        #1 bus_a.in_valid = 1'b0;
        cyc = 0;
        while (!bus_a.out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({name, " latency"}, cyc, 4);
        check({name, " busy"}, int'(bus_a.busy), 1);
        check({name, " in_ready done"}, int'(bus_a.in_ready), 0);
        want = (sb_a.size() > 0) ? sb_a.pop_front() : -1;
        check({name, " sum"}, int'(bus_a.out_sum), want);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({name, " held valid"}, int'(bus_a.out_valid), 1);
            check({name, " held sum"}, int'(bus_a.out_sum), want);
            check({name, " held in_ready"}, int'(bus_a.in_ready), 0);
        end
        bus_a.out_ready = 1'b1;
        @(posedge clk);
        #1 bus_a.out_ready = 1'b0;
        check({name, " post valid"}, int'(bus_a.out_valid), 0);
        check({name, " post in_ready"}, int'(bus_a.in_ready), 1);
        check({name, " post busy"}, int'(bus_a.busy), 0);
        check({name, " post sum"}, int'(bus_a.out_sum), 0);
    endtask

    initial begin
        vecs[0] = '{20'hFFFFF, 4'hF, 28, "all_ones"};
        vecs[1] = '{20'h00000, 4'h0, 0,  "zero"};
        vecs[2] = '{20'h80000, 4'h0, 1,  "last_one"};
        vecs[3] = '{20'h00000, 4'h8, 2,  "last_two"};
        vecs[4] = '{20'hAAAAA, 4'h5, 14, "alt"};
        vecs[5] = '{20'h0001F, 4'h0, 5,  "low_slice"};
        vecs[6] = '{20'hF0000, 4'hF, 12, "hi_ones_twos"};

        bus_a.in_valid  = 1'b0;
        bus_a.in_ones   = '0;
        bus_a.in_twos   = '0;
        bus_a.out_ready = 1'b0;
        bus_b.in_valid  = 1'b0;
        bus_b.in_ones   = '0;
        bus_b.in_twos   = '0;
        bus_b.out_ready = 1'b0;

        fork
            begin
                repeat (3) @(negedge clk);
                check("reset in_ready", int'(bus_a.in_ready), 1);
                check("reset out_valid", int'(bus_a.out_valid), 0);
                check("reset busy", int'(bus_a.busy), 0);
                check("reset out_sum", int'(bus_a.out_sum), 0);
                rst_n = 1'b1;

                // out_ready with nothing pending must not disturb IDLE.
                @(negedge clk);
                bus_a.out_ready = 1'b1;
                @(negedge clk);
                bus_a.out_ready = 1'b0;
                check("idle out_ready valid", int'(bus_a.out_valid), 0);
                check("idle out_ready in_ready", int'(bus_a.in_ready), 1);

                for (int i = 0; i < 7; i++) begin
                    send_a(vecs[i].ones, vecs[i].twos, vecs[i].exp, vecs[i].name, 0);
                end

                send_a(20'h12345, 4'h3, 11, "hold", 3);
                send_a(20'h00001, 4'h1, 3, "after_hold", 0);

                // Reset in the second RUN cycle discards the operand.
                @(negedge clk);
                bus_a.in_ones  = 20'hFFFFF;
                bus_a.in_twos  = 4'hF;
                bus_a.in_valid = 1'b1;
                @(posedge clk);
                #1 bus_a.in_valid = 1'b0;
                @(posedge clk);
                #1;
                check("mid run busy", int'(bus_a.busy), 1);
                #1 rst_n = 1'b0;
                #1;
                check("async rst out_valid", int'(bus_a.out_valid), 0);
                check("async rst in_ready", int'(bus_a.in_ready), 1);
                check("async rst busy", int'(bus_a.busy), 0);
                check("async rst out_sum", int'(bus_a.out_sum), 0);
                @(negedge clk);
                rst_n = 1'b1;
                send_a(20'h0001F, 4'h0, 5, "after_rst", 0);

                // Random traffic on the small instance with random back-pressure.
                fork
                    begin
                        int cyc;
                        int unsigned r;
                        for (int n = 0; n < 1000; n++) begin
                            @(negedge clk);
                            r = $urandom;
                            bus_b.in_ones  = r[6:0];
                            bus_b.in_twos  = r[7:7];
                            bus_b.in_valid = 1'b1;
                            cyc = 0;
                            while (!bus_b.in_ready && cyc < 50) begin
                                @(negedge clk);
                                cyc++;
                            end
                            if (cyc >= 50) begin
                                check("b accept timeout", cyc, 0);
                                break;
                            end
                            @(posedge clk);
                            sb_b.push_back($countones(bus_b.in_ones)
                                           + 2 * $countones(bus_b.in_twos));
                            #1 bus_b.in_valid = 1'b0;
                        end
                        cyc = 0;
                        while (sb_b.size() > 0 && cyc < 100) begin
                            @(negedge clk);
                            cyc++;
                        end
                        check("b drain", sb_b.size(), 0);
                        b_done = 1'b1;
                    end
                    begin
                        while (!b_done) begin
                            @(negedge clk);
                            bus_b.out_ready = 1'($urandom_range(0, 1));
                            if (bus_b.out_valid && bus_b.out_ready) begin
                                if (sb_b.size() == 0) check("b unexpected out", 1, 0);
                                else check("b sum", int'(bus_b.out_sum), sb_b.pop_front());
                            end
                        end
                        bus_b.out_ready = 1'b0;
                    end
                join
            end
            begin
                forever begin
                    @(negedge clk);
                    check("a ready&busy", int'(bus_a.in_ready && bus_a.busy), 0);
                    check("b ready&busy", int'(bus_b.in_ready && bus_b.busy), 0);
                end
            end
            begin
                #2000000;
                check("global timeout", 1, 0);
            end
        join_any
        disable fork;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
